// File: rtl/axi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axi_pkg
//  Description : Shared AXI3 encodings, FSM state codes, stall-LFSR constants
//                and the per-beat address step helper for axi_sram_slave.
//  Revision    : 1.0 - initial release
// ============================================================================
package axi_pkg;

    // Burst type encodings
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    // Response encodings
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Slave FSM state codes
    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_RD       = 2'd1;
    localparam logic [1:0] ST_WR_DATA  = 2'd2;
    localparam logic [1:0] ST_WR_RESP  = 2'd3;

    // Stall LFSR: x^16 + x^14 + x^13 + x^11 (bit 15,13,12,10 of the register)
    localparam logic [15:0] LFSR_SEED  = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS  = 16'hB400;

    // Byte address of the next beat: FIXED holds, INCR steps by the beat
    // size; sizes wider than the 32-bit bus step by one word.
    function automatic logic [31:0] next_addr(input logic [31:0] addr,
                                              input logic [2:0]  size,
                                              input logic [1:0]  burst);
        logic [31:0] step;
        step = (size > 3'd2) ? 32'd4 : (32'd1 << size);
        return (burst == BURST_INCR) ? (addr + step) : addr;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi_rd_skid.sv
`default_nettype none
// ============================================================================
//  Module      : axi_rd_skid
//  Description : Two-entry read-data FIFO between the SRAM read port and the
//                AXI R channel. Holds {rdata, rlast, rresp} and reports its
//                occupancy so the issuer never overruns it.
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_rd_skid #(
    parameter int WIDTH = 35
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic [1:0]       occ
);

    logic [WIDTH-1:0] mem_q [0:1];
    logic [WIDTH-1:0] mem_d [0:1];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_pop  = pop && (count_q != 2'd0);
    assign w_do_push = push && ((count_q != 2'd2) || w_do_pop);

    // Next-state for storage, pointers and occupancy
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (w_do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (w_do_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + {1'b0, w_do_push} - {1'b0, w_do_pop};
    end

    // FIFO state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign empty = (count_q == 2'd0);
    assign occ   = count_q;

endmodule
`default_nettype wire

// File: rtl/axi_sram_slave.sv
`default_nettype none
// ============================================================================
//  Module      : axi_sram_slave
//  Description : AXI3 slave fronting a single-port synchronous word SRAM
//                (1-cycle read latency). One transaction at a time, reads
//                and writes arbitrated round-robin, FIXED/INCR bursts up to
//                256 beats; WRAP/reserved bursts answer SLVERR.
//                Optional macro AXI_SLV_STALL_EN: LFSR-driven gating of
//                arready/awready/wready to stress the master.
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_sram_slave
    import axi_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int ID_W   = 4
) (
    input  logic              aclk,
    input  logic              aresetn,
    // Read address
    input  logic [ID_W-1:0]   arid,
    input  logic [31:0]       araddr,
    input  logic [7:0]        arlen,
    input  logic [2:0]        arsize,
    input  logic [1:0]        arburst,
    input  logic              arvalid,
    output logic              arready,
    // Read data
    output logic [ID_W-1:0]   rid,
    output logic [31:0]       rdata,
    output logic [1:0]        rresp,
    output logic              rlast,
    output logic              rvalid,
    input  logic              rready,
    // Write address
    input  logic [ID_W-1:0]   awid,
    input  logic [31:0]       awaddr,
    input  logic [7:0]        awlen,
    input  logic [2:0]        awsize,
    input  logic [1:0]        awburst,
    input  logic              awvalid,
    output logic              awready,
    // Write data
    input  logic [ID_W-1:0]   wid,
    input  logic [31:0]       wdata,
    input  logic [3:0]        wstrb,
    input  logic              wlast,
    input  logic              wvalid,
    output logic              wready,
    // Write response
    output logic [ID_W-1:0]   bid,
    output logic [1:0]        bresp,
    output logic              bvalid,
    input  logic              bready,
    // SRAM port
    output logic              ram_en,
    output logic [3:0]        ram_wen,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    logic [1:0]      state_q, state_d;
    logic [ID_W-1:0] id_q, id_d;
    logic [31:0]     addr_q, addr_d;
    logic [7:0]      len_q, len_d;
    logic [2:0]      size_q, size_d;
    logic [1:0]      burst_q, burst_d;
    logic [8:0]      beat_q, beat_d;          // reads issued / writes accepted
    logic            inflight_q, inflight_d;  // SRAM read launched last cycle
    logic            infl_last_q, infl_last_d;
    logic            err_q, err_d;
    logic            last_grant_q, last_grant_d; // 1 = write won last time

    logic            w_stall;
    logic            w_bad_burst;
    logic            w_last_beat;
    logic            w_grant_rd;
    logic            w_room;
    logic            w_push;
    logic            w_pop;
    logic [34:0]     w_push_data;
    logic [34:0]     w_head;
    logic            w_empty;
    logic [1:0]      w_occ;
    logic            w_unused;

    assign w_unused = ^wid;

`ifdef AXI_SLV_STALL_EN
    logic [15:0] lfsr_q, lfsr_d;

    // Fibonacci LFSR free-running every cycle
    always_comb begin
        lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
    end

    // LFSR register
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign w_stall = (lfsr_q[1:0] == 2'b00);
`else
    assign w_stall = 1'b0;
`endif

    assign w_bad_burst = (burst_q != BURST_FIXED) && (burst_q != BURST_INCR);
    assign w_last_beat = (beat_q == {1'b0, len_q});

    // Read data returns one cycle after the strobe straight into the FIFO;
    // bad bursts still read but the data is squashed to zero.
    assign w_push      = inflight_q;
    assign w_push_data = {(w_bad_burst ? 32'h0 : ram_rdata),
                          infl_last_q,
                          (w_bad_burst ? RESP_SLVERR : RESP_OKAY)};
    assign w_pop       = rvalid && rready;

    // A slot frees this cycle when the head is popped, which keeps the
    // issue rate at one beat per cycle while rready is held high.
    assign w_room = (({1'b0, w_occ} + {2'b00, inflight_q}) < (3'd2 + {2'b00, w_pop}));

    axi_rd_skid #(
        .WIDTH (35)
    ) u_rd_skid (
        .clk       (aclk),
        .rst_n     (aresetn),
        .push      (w_push),
        .push_data (w_push_data),
        .pop       (w_pop),
        .head      (w_head),
        .empty     (w_empty),
        .occ       (w_occ)
    );

    assign rvalid                = !w_empty;
    assign {rdata, rlast, rresp} = w_head;
    assign rid                   = id_q;
    assign bid                   = id_q;
    assign bresp                 = (err_q || w_bad_burst) ? RESP_SLVERR : RESP_OKAY;

    // Transaction FSM: arbitration, SRAM strobes and channel readies
    always_comb begin
        state_d      = state_q;
        id_d         = id_q;
        addr_d       = addr_q;
        len_d        = len_q;
        size_d       = size_q;
        burst_d      = burst_q;
        beat_d       = beat_q;
        inflight_d   = 1'b0;
        infl_last_d  = infl_last_q;
        err_d        = err_q;
        last_grant_d = last_grant_q;
        arready      = 1'b0;
        awready      = 1'b0;
        wready       = 1'b0;
        bvalid       = 1'b0;
        ram_en       = 1'b0;
        ram_wen      = 4'h0;
        ram_addr     = addr_q[ADDR_W+1:2];
        ram_wdata    = wdata;
        w_grant_rd   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                w_grant_rd = arvalid && (!awvalid || last_grant_q);
                arready    = w_grant_rd && !w_stall;
                awready    = awvalid && !w_grant_rd && !w_stall;
                if (arready) begin
                    id_d         = arid;
                    addr_d       = araddr;
                    len_d        = arlen;
                    size_d       = arsize;
                    burst_d      = arburst;
                    beat_d       = 9'd0;
                    last_grant_d = 1'b0;
                    state_d      = ST_RD;
                end else if (awready) begin
                    id_d         = awid;
                    addr_d       = awaddr;
                    len_d        = awlen;
                    size_d       = awsize;
                    burst_d      = awburst;
                    beat_d       = 9'd0;
                    err_d        = 1'b0;
                    last_grant_d = 1'b1;
                    state_d      = ST_WR_DATA;
                end
            end

            ST_RD: begin
                if (w_room && (beat_q <= {1'b0, len_q})) begin
                    ram_en      = 1'b1;
                    inflight_d  = 1'b1;
                    infl_last_d = w_last_beat;
                    beat_d      = beat_q + 9'd1;
                    addr_d      = next_addr(addr_q, size_q, burst_q);
                end
                if (w_pop && rlast) begin
                    state_d = ST_IDLE;
                end
            end

            ST_WR_DATA: begin
                wready = !w_stall;
                if (wvalid && wready) begin
                    ram_en  = !w_bad_burst;
                    ram_wen = w_bad_burst ? 4'h0 : wstrb;
                    beat_d  = beat_q + 9'd1;
                    addr_d  = next_addr(addr_q, size_q, burst_q);
                    if (wlast != w_last_beat) begin
                        err_d = 1'b1;
                    end
                    if (w_last_beat) begin
                        state_d = ST_WR_RESP;
                    end
                end
            end

            ST_WR_RESP: begin
                bvalid = 1'b1;
                if (bready) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Transaction context registers
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= ST_IDLE;
            id_q         <= '0;
            addr_q       <= 32'h0;
            len_q        <= 8'h0;
            size_q       <= 3'h0;
            burst_q      <= BURST_FIXED;
            beat_q       <= 9'h0;
            inflight_q   <= 1'b0;
            infl_last_q  <= 1'b0;
            err_q        <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            id_q         <= id_d;
            addr_q       <= addr_d;
            len_q        <= len_d;
            size_q       <= size_d;
            burst_q      <= burst_d;
            beat_q       <= beat_d;
            inflight_q   <= inflight_d;
            infl_last_q  <= infl_last_d;
            err_q        <= err_d;
            last_grant_q <= last_grant_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_sram_slave.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi_sram_slave
//  Description : Self-checking bench for axi_sram_slave: directed scenarios
//                followed by randomized transactions against a word-array
//                reference memory.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_sram_slave;

    localparam int          ADDR_W = 16;
    localparam int          ID_W   = 4;
    localparam logic [31:0] AMASK  = (32'h1 << ADDR_W) - 32'h1;

    logic              aclk    = 1'b0;
    logic              aresetn = 1'b0;
    logic [ID_W-1:0]   arid    = '0;
    logic [31:0]       araddr  = '0;
    logic [7:0]        arlen   = '0;
    logic [2:0]        arsize  = '0;
    logic [1:0]        arburst = '0;
    logic              arvalid = 1'b0;
    logic              arready;
    logic [ID_W-1:0]   rid;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready  = 1'b0;
    logic [ID_W-1:0]   awid    = '0;
    logic [31:0]       awaddr  = '0;
    logic [7:0]        awlen   = '0;
    logic [2:0]        awsize  = '0;
    logic [1:0]        awburst = '0;
    logic              awvalid = 1'b0;
    logic              awready;
    logic [ID_W-1:0]   wid     = '0;
    logic [31:0]       wdata   = '0;
    logic [3:0]        wstrb   = '0;
    logic              wlast   = 1'b0;
    logic              wvalid  = 1'b0;
    logic              wready;
    logic [ID_W-1:0]   bid;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready  = 1'b0;
    logic              ram_en;
    logic [3:0]        ram_wen;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 aclk = ~aclk;

    axi_sram_slave #(.ADDR_W(ADDR_W), .ID_W(ID_W)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .ram_en(ram_en), .ram_wen(ram_wen), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    // SRAM behind the DUT, with a backdoor load port for preloading
    logic [31:0] sram [int];
    logic        bd_we   = 1'b0;
    int          bd_word = 0;
    logic [31:0] bd_data = '0;
    logic [31:0] sw;

    always @(posedge aclk) begin
        if (bd_we) sram[bd_word] = bd_data;
        if (ram_en) begin
            if (ram_wen == 4'h0) begin
                ram_rdata <= sram.exists(int'(ram_addr)) ? sram[int'(ram_addr)] : 32'h0;
            end else begin
                sw = sram.exists(int'(ram_addr)) ? sram[int'(ram_addr)] : 32'h0;
                for (int b = 0; b < 4; b++)
                    if (ram_wen[b]) sw[8*b +: 8] = ram_wdata[8*b +: 8];
                sram[int'(ram_addr)] = sw;
            end
        end
    end

    // Reference memory
    logic [31:0] model [int];
    logic [31:0] wd [256];
    logic [3:0]  ws [256];
    logic        wl [256];

    function automatic logic [31:0] mrd(input int w);
        return model.exists(w) ? model[w] : 32'h0;
    endfunction

    // Word touched by beat k: INCR walks by 2^min(size,2) bytes, FIXED stays
    function automatic int beat_word(input logic [31:0] addr, input logic [2:0] size,
                                     input logic [1:0] burst, input int k);
        logic [31:0] ba;
        int          step;
        step = (size > 3'd2) ? 4 : (1 << size);
        ba   = (burst == 2'b01) ? addr + 32'(k * step) : addr;
        return int'((ba >> 2) & AMASK);
    endfunction

    function automatic bit is_bad(input logic [1:0] burst);
        return (burst != 2'b00) && (burst != 2'b01);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input int w, input logic [31:0] d);
        @(negedge aclk);
        bd_we = 1'b1; bd_word = w; bd_data = d;
        @(negedge aclk);
        bd_we = 1'b0;
        model[w] = d;
    endtask

    // Called at a negedge; returns at the negedge after the AR handshake
    task automatic ar_start(input logic [ID_W-1:0] id, input logic [31:0] addr,
                            input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
        bit hs, ok;
        arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst;
        arvalid = 1'b1; ok = 1'b0;
        for (int t = 0; t < 64; t++) begin
            #1; hs = arready;
            @(posedge aclk);
            if (hs) begin ok = 1'b1; break; end
            @(negedge aclk);
        end
        if (!ok) check("ar_handshake", 64'(ok), 64'd1);
        @(negedge aclk);
        arvalid = 1'b0;
    endtask

    task automatic aw_start(input logic [ID_W-1:0] id, input logic [31:0] addr,
                            input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
        bit hs, ok;
        awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst;
        awvalid = 1'b1; ok = 1'b0;
        for (int t = 0; t < 64; t++) begin
            #1; hs = awready;
            @(posedge aclk);
            if (hs) begin ok = 1'b1; break; end
            @(negedge aclk);
        end
        if (!ok) check("aw_handshake", 64'(ok), 64'd1);
        @(negedge aclk);
        awvalid = 1'b0;
    endtask

    // rmode: 0 = rready held high, 1 = toggling, 2 = random
    task automatic rd_collect(input logic [ID_W-1:0] id, input logic [31:0] addr,
                              input logic [7:0] len, input logic [2:0] size,
                              input logic [1:0] burst, input int rmode);
        int k, lat, lat_first, t;
        bit seen, bad;
        logic [31:0] ed;
        k = 0; lat = 0; lat_first = 0; t = 0; seen = 1'b0;
        bad = is_bad(burst);
        while (k <= int'(len)) begin
            case (rmode)
                0:       rready = 1'b1;
                1:       rready = (t % 2 == 0);
                default: rready = 1'($urandom_range(0, 1));
            endcase
            #1;
            if (rvalid) begin
                ed = bad ? 32'h0 : mrd(beat_word(addr, size, burst, k));
                if (!seen) begin
                    check("rd_first_latency", 64'(lat), 64'd2);
                    lat_first = lat; seen = 1'b1;
                end
                check("rdata", 64'(rdata), 64'(ed));
                check("rlast", 64'(rlast), 64'(k == int'(len)));
                check("rresp", 64'(rresp), bad ? 64'd2 : 64'd0);
                check("rid",   64'(rid),   64'(id));
                if (rready) begin
                    if (k == int'(len) && rmode == 0)
                        check("rd_throughput", 64'(lat - lat_first), 64'(len));
                    k++;
                end
            end
            @(posedge aclk);
            lat++; t++;
            if (t > 2000) begin check("rd_beats", 64'(k), 64'(int'(len) + 1)); break; end
            @(negedge aclk);
        end
        rready = 1'b0;
    endtask

    task automatic do_read(input logic [ID_W-1:0] id, input logic [31:0] addr,
                           input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input int rmode);
        ar_start(id, addr, len, size, burst);
        rd_collect(id, addr, len, size, burst, rmode);
    endtask

    // Sends len+1 beats from wd/ws/wl; updates the model; returns wlast error
    task automatic w_send(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input bit bubbles, output bit err);
        int k, t, w;
        bit hs;
        logic [31:0] cur;
        k = 0; t = 0; err = 1'b0;
        while (k <= int'(len)) begin
            wvalid = bubbles ? ($urandom_range(0, 3) != 0) : 1'b1;
            wdata = wd[k]; wstrb = ws[k]; wlast = wl[k];
            #1; hs = wvalid && wready;
            @(posedge aclk);
            if (hs) begin
                if (!is_bad(burst)) begin
                    w = beat_word(addr, size, burst, k);
                    cur = mrd(w);
                    for (int b = 0; b < 4; b++)
                        if (ws[k][b]) cur[8*b +: 8] = wd[k][8*b +: 8];
                    model[w] = cur;
                end
                if (wl[k] != (k == int'(len))) err = 1'b1;
                k++;
            end
            t++;
            if (t > 2000) begin check("w_beats", 64'(k), 64'(int'(len) + 1)); break; end
            @(negedge aclk);
        end
        wvalid = 1'b0; wlast = 1'b0;
    endtask

    task automatic b_get(input logic [ID_W-1:0] id, input logic [1:0] exp_resp, input bit rnd);
        bit hs, done, first;
        int t;
        done = 1'b0; first = 1'b1; t = 0;
        while (!done) begin
            bready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (first) begin check("wready_after_last", 64'(wready), 64'd0); first = 1'b0; end
            if (bvalid) begin
                check("bresp", 64'(bresp), 64'(exp_resp));
                check("bid",   64'(bid),   64'(id));
            end
            hs = bvalid && bready;
            @(posedge aclk);
            if (hs) done = 1'b1;
            t++;
            if (!done && t > 200) begin check("b_handshake", 64'(done), 64'd1); break; end
            @(negedge aclk);
        end
        bready = 1'b0;
    endtask

    task automatic do_write(input logic [ID_W-1:0] id, input logic [31:0] addr,
                            input logic [7:0] len, input logic [2:0] size,
                            input logic [1:0] burst, input bit rnd);
        bit err;
        aw_start(id, addr, len, size, burst);
        w_send(addr, len, size, burst, rnd, err);
        b_get(id, (err || is_bad(burst)) ? 2'b10 : 2'b00, rnd);
    endtask

    // Wait (at a negedge) until either address ready rises; leaves us #1 after
    task automatic wait_addr_ready();
        bit got;
        got = 1'b0;
        for (int t = 0; t < 64; t++) begin
            #1;
            if (arready || awready) begin got = 1'b1; break; end
            @(posedge aclk);
            @(negedge aclk);
        end
        if (!got) check("arb_ready_seen", 64'(got), 64'd1);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          err;
        logic [1:0]  bsel;
        logic [7:0]  rlen;
        logic [31:0] raddr;
        logic [2:0]  rsize;

        // ---- reset state ----
        repeat (2) @(negedge aclk);
        #1;
        check("rst_arready", 64'(arready), 64'd0);
        check("rst_awready", 64'(awready), 64'd0);
        check("rst_wready",  64'(wready),  64'd0);
        check("rst_rvalid",  64'(rvalid),  64'd0);
        check("rst_bvalid",  64'(bvalid),  64'd0);
        check("rst_ram_en",  64'(ram_en),  64'd0);
        check("rst_ram_wen", 64'(ram_wen), 64'd0);
        check("rst_rdata",   64'(rdata),   64'd0);
        check("rst_rid",     64'(rid),     64'd0);
        check("rst_rresp",   64'(rresp),   64'd0);
        check("rst_bid",     64'(bid),     64'd0);
        check("rst_bresp",   64'(bresp),   64'd0);
        @(negedge aclk);
        aresetn = 1'b1;

        // ---- single read of a preloaded word ----
        preload(32'h10, 32'hDEADBEEF);
        do_read(4'h5, 32'h40, 8'd0, 3'd2, 2'b01, 0);

        // ---- INCR 4-beat read with toggling rready ----
        preload(32'h40, 32'h11110000);
        preload(32'h41, 32'h22221111);
        preload(32'h42, 32'h33332222);
        preload(32'h43, 32'h44443333);
        do_read(4'hA, 32'h100, 8'd3, 3'd2, 2'b01, 1);

        // ---- longer INCR read at full rate ----
        do_read(4'h1, 32'h100, 8'd7, 3'd2, 2'b01, 0);

        // ---- partial-strobe write, then read back ----
        preload(32'h8, 32'hAABBCCDD);
        wd[0] = 32'h12345678; ws[0] = 4'b0011; wl[0] = 1'b1;
        do_write(4'h9, 32'h20, 8'd0, 3'd2, 2'b01, 1'b0);
        do_read(4'h3, 32'h20, 8'd0, 3'd2, 2'b01, 0);

        // ---- WRAP read: zero data, SLVERR ----
        do_read(4'h7, 32'h100, 8'd1, 3'd2, 2'b10, 0);

        // ---- FIXED write of three beats lands on one word ----
        for (int i = 0; i < 3; i++) begin wd[i] = 32'(i + 1); ws[i] = 4'hF; wl[i] = (i == 2); end
        do_write(4'h4, 32'h8, 8'd2, 3'd2, 2'b00, 1'b0);
        do_read(4'h4, 32'h8, 8'd0, 3'd2, 2'b01, 0);

        // ---- early wlast -> SLVERR ----
        wd[0] = 32'hCAFE0001; ws[0] = 4'hF; wl[0] = 1'b1;
        wd[1] = 32'hCAFE0002; ws[1] = 4'hF; wl[1] = 1'b1;
        do_write(4'h2, 32'h300, 8'd1, 3'd2, 2'b01, 1'b0);

        // ---- reset mid-read ----
        ar_start(4'h3, 32'h100, 8'd7, 3'd2, 2'b01);
        repeat (3) @(negedge aclk);
        #1;
        check("mid_rst_rvalid_before", 64'(rvalid), 64'd1);
        aresetn = 1'b0;
        #1;
        check("mid_rst_rvalid", 64'(rvalid), 64'd0);
        check("mid_rst_bvalid", 64'(bvalid), 64'd0);
        check("mid_rst_ram_en", 64'(ram_en), 64'd0);
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        #1;
        check("post_rst_rvalid", 64'(rvalid), 64'd0);
        @(negedge aclk);

        // ---- simultaneous AR/AW twice: read first, then write ----
        arid = 4'h8; araddr = 32'h104; arlen = 8'd0; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b1;
        awid = 4'hC; awaddr = 32'h44; awlen = 8'd0; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b1;
        wait_addr_ready();
        check("arb1_arready", 64'(arready), 64'd1);
        check("arb1_awready", 64'(awready), 64'd0);
        @(posedge aclk);
        @(negedge aclk);
        arvalid = 1'b0;
        rd_collect(4'h8, 32'h104, 8'd0, 3'd2, 2'b01, 0);
        arvalid = 1'b1;
        wait_addr_ready();
        check("arb2_awready", 64'(awready), 64'd1);
        check("arb2_arready", 64'(arready), 64'd0);
        @(posedge aclk);
        @(negedge aclk);
        awvalid = 1'b0;
        wd[0] = 32'h5A5A_A5A5; ws[0] = 4'hF; wl[0] = 1'b1;
        w_send(32'h44, 8'd0, 3'd2, 2'b01, 1'b0, err);
        b_get(4'hC, 2'b00, 1'b0);
        do_read(4'h8, 32'h104, 8'd0, 3'd2, 2'b01, 0);
        do_read(4'hD, 32'h44, 8'd0, 3'd2, 2'b01, 2);

        // ---- randomized traffic ----
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: bsel = 2'b01;
                6, 7:             bsel = 2'b00;
                8:                bsel = 2'b10;
                default:          bsel = 2'b11;
            endcase
            rlen  = 8'($urandom_range(0, 15));
            rsize = 3'($urandom_range(0, 3));
            raddr = 32'($urandom_range(0, 32'h3FF));
            if ($urandom_range(0, 1) == 0) begin
                do_read(4'($urandom), raddr, rlen, rsize, bsel, int'($urandom_range(0, 2)));
            end else begin
                for (int i = 0; i <= int'(rlen); i++) begin
                    wd[i] = $urandom;
                    ws[i] = 4'($urandom);
                    wl[i] = (i == int'(rlen));
                end
                if ($urandom_range(0, 9) == 0) wl[rlen] = 1'b0;
                do_write(4'($urandom), raddr, rlen, rsize, bsel, 1'b1);
            end
        end

        // Final sweep of the touched region against the reference
        do_read(4'hE, 32'h0, 8'd255, 3'd2, 2'b01, 2);
        do_read(4'hF, 32'h400, 8'd15, 3'd2, 2'b01, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
